// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped 2-bit counter predictor with BTB, mispredict detect and stats
module branch_predictor #(
  parameter int XLEN         = 32,
  parameter int ENTRIES      = 16,
  parameter int TAG_BITS     = 8,
  parameter int COUNTER_INIT = 1,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [XLEN-1:0]       if_pc,
  output logic                  if_predict_taken,
  output logic [XLEN-1:0]       if_predict_target,
  output logic                  if_predict_hit,
  input  logic                  ex_update_valid,
  input  logic [XLEN-1:0]       ex_pc,
  input  logic                  ex_taken,
  input  logic [XLEN-1:0]       ex_target,
  input  logic                  ex_predicted_taken,
  input  logic [XLEN-1:0]       ex_predicted_target,
  output logic                  ex_mispredict,
  output logic [XLEN-1:0]       ex_redirect_pc,
  output logic [STAT_WIDTH-1:0] stat_updates,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int IDX = $clog2(ENTRIES);
  localparam logic [1:0] CTR_INIT = 2'(COUNTER_INIT);

  logic                valid   [ENTRIES];
  logic [TAG_BITS-1:0] tags    [ENTRIES];
  logic [XLEN-1:0]     targets [ENTRIES];
  logic [1:0]          ctrs    [ENTRIES];

  logic [IDX-1:0]      if_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic [IDX-1:0]      ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                ex_hit;

  assign if_idx = if_pc[IDX+1:2];
  assign if_tag = if_pc[IDX+TAG_BITS+1:IDX+2];
  assign ex_idx = ex_pc[IDX+1:2];
  assign ex_tag = ex_pc[IDX+TAG_BITS+1:IDX+2];

  // IF reads the registered table only, so a same-cycle EX write is not bypassed
  assign if_predict_hit    = valid[if_idx] && (tags[if_idx] == if_tag);
  assign if_predict_taken  = if_predict_hit && ctrs[if_idx][1];
  assign if_predict_target = if_predict_hit ? targets[if_idx] : if_pc + XLEN'(4);

  assign ex_hit = valid[ex_idx] && (tags[ex_idx] == ex_tag);

  assign ex_mispredict  = ex_update_valid &&
                          ((ex_taken != ex_predicted_taken) ||
                           (ex_taken && (ex_target != ex_predicted_target)));
  assign ex_redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        ctrs[i]  <= CTR_INIT;
      end
    end else if (ex_update_valid) begin
      if (ex_hit) begin
        if (ex_taken && ctrs[ex_idx] != 2'd3) begin
          ctrs[ex_idx] <= ctrs[ex_idx] + 2'd1;
        end else if (!ex_taken && ctrs[ex_idx] != 2'd0) begin
          ctrs[ex_idx] <= ctrs[ex_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        valid[ex_idx] <= 1'b1;
        ctrs[ex_idx]  <= 2'd2;
      end
    end
  end

  // Tag/target carry no reset; a stale write is harmless while valid is clear
  always_ff @(posedge clock) begin
    if (ex_update_valid && ex_taken) begin
      tags[ex_idx]    <= ex_tag;
      targets[ex_idx] <= ex_target;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (ex_update_valid && !(&stat_updates)) begin
        stat_updates <= stat_updates + STAT_WIDTH'(1);
      end
      if (ex_mispredict && !(&stat_mispredicts)) begin
        stat_mispredicts <= stat_mispredicts + STAT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed vector bench for branch_predictor
module tb_branch_predictor;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] if_pc;
  logic        ex_update_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_predicted_taken;
  logic [31:0] ex_predicted_target;

  logic        if_predict_taken, if_predict_hit, ex_mispredict;
  logic [31:0] if_predict_target, ex_redirect_pc;
  logic [15:0] stat_updates, stat_mispredicts;

  logic        s_predict_taken, s_predict_hit, s_mispredict;
  logic [31:0] s_predict_target, s_redirect_pc;
  logic [3:0]  s_updates, s_mispredicts;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_upd = 0;
  int exp_mis = 0;

  always #5 clock = ~clock;

  branch_predictor dut (
    .clock(clock), .reset_n(reset_n), .if_pc(if_pc),
    .if_predict_taken(if_predict_taken), .if_predict_target(if_predict_target),
    .if_predict_hit(if_predict_hit), .ex_update_valid(ex_update_valid),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_predicted_taken(ex_predicted_taken), .ex_predicted_target(ex_predicted_target),
    .ex_mispredict(ex_mispredict), .ex_redirect_pc(ex_redirect_pc),
    .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
  );

  branch_predictor #(.STAT_WIDTH(4)) dut_small (
    .clock(clock), .reset_n(reset_n), .if_pc(if_pc),
    .if_predict_taken(s_predict_taken), .if_predict_target(s_predict_target),
    .if_predict_hit(s_predict_hit), .ex_update_valid(ex_update_valid),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_predicted_taken(ex_predicted_taken), .ex_predicted_target(ex_predicted_target),
    .ex_mispredict(s_mispredict), .ex_redirect_pc(s_redirect_pc),
    .stat_updates(s_updates), .stat_mispredicts(s_mispredicts)
  );

  typedef struct {
    logic        upd;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
    logic        ptaken;
    logic [31:0] ptgt;
    logic [31:0] ifpc;
    logic        mis;
    logic [31:0] redir;
    logic        hit;
    logic        ptk;
    logic [31:0] ptarget;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic upd, input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt,
                       input logic [31:0] ifpc);
    ex_update_valid     = upd;
    ex_pc               = pc;
    ex_taken            = taken;
    ex_target           = tgt;
    ex_predicted_taken  = ptaken;
    ex_predicted_target = ptgt;
    if_pc               = ifpc;
  endtask

  initial begin
    // IF-side expectations describe the table before that row's update lands
    vecs[0]  = '{0, 32'h0,    0, 32'h0,   0, 32'h0,   32'h40,   0, 32'h4,   0, 0, 32'h44};
    vecs[1]  = '{1, 32'h40,   1, 32'h100, 0, 32'h0,   32'h40,   1, 32'h100, 0, 0, 32'h44};
    vecs[2]  = '{1, 32'h40,   0, 32'h0,   1, 32'h100, 32'h40,   1, 32'h44,  1, 1, 32'h100};
    vecs[3]  = '{1, 32'h40,   0, 32'h0,   0, 32'h0,   32'h40,   0, 32'h44,  1, 0, 32'h100};
    vecs[4]  = '{1, 32'h40,   0, 32'h0,   0, 32'h0,   32'h40,   0, 32'h44,  1, 0, 32'h100};
    vecs[5]  = '{1, 32'h40,   1, 32'h200, 0, 32'h0,   32'h40,   1, 32'h200, 1, 0, 32'h100};
    vecs[6]  = '{0, 32'h0,    0, 32'h0,   0, 32'h0,   32'h40,   0, 32'h4,   1, 0, 32'h200};
    vecs[7]  = '{1, 32'h40,   1, 32'h200, 0, 32'h200, 32'h40,   1, 32'h200, 1, 0, 32'h200};
    vecs[8]  = '{1, 32'h40,   1, 32'h200, 1, 32'h200, 32'h40,   0, 32'h200, 1, 1, 32'h200};
    vecs[9]  = '{1, 32'h40,   1, 32'h300, 1, 32'h200, 32'h40,   1, 32'h300, 1, 1, 32'h200};
    vecs[10] = '{1, 32'h40,   0, 32'h0,   1, 32'h300, 32'h40,   1, 32'h44,  1, 1, 32'h300};
    vecs[11] = '{0, 32'h0,    0, 32'h0,   0, 32'h0,   32'h40,   0, 32'h4,   1, 1, 32'h300};
    vecs[12] = '{1, 32'h84,   0, 32'h0,   0, 32'h0,   32'h84,   0, 32'h88,  0, 0, 32'h88};
    vecs[13] = '{0, 32'h0,    0, 32'h0,   0, 32'h0,   32'h84,   0, 32'h4,   0, 0, 32'h88};
    vecs[14] = '{1, 32'h80,   1, 32'h500, 0, 32'h0,   32'h80,   1, 32'h500, 0, 0, 32'h84};
    vecs[15] = '{0, 32'h0,    0, 32'h0,   0, 32'h0,   32'h40,   0, 32'h4,   0, 0, 32'h44};
    vecs[16] = '{0, 32'h0,    0, 32'h0,   0, 32'h0,   32'h80,   0, 32'h4,   1, 1, 32'h500};
    vecs[17] = '{0, 32'h0,    0, 32'h0,   0, 32'h0,   32'h4080, 0, 32'h4,   1, 1, 32'h500};
    vecs[18] = '{0, 32'h80,   1, 32'h600, 0, 32'h0,   32'h80,   0, 32'h600, 1, 1, 32'h500};

    drive(0, 0, 0, 0, 0, 0, 32'h40);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("reset stat_updates", 32'(stat_updates), 0);
    check("reset stat_mispredicts", 32'(stat_mispredicts), 0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clock);
      drive(vecs[i].upd, vecs[i].pc, vecs[i].taken, vecs[i].tgt,
            vecs[i].ptaken, vecs[i].ptgt, vecs[i].ifpc);
      #1;
      check($sformatf("v%0d mispredict", i), 32'(ex_mispredict), 32'(vecs[i].mis));
      check($sformatf("v%0d redirect", i), ex_redirect_pc, vecs[i].redir);
      check($sformatf("v%0d hit", i), 32'(if_predict_hit), 32'(vecs[i].hit));
      check($sformatf("v%0d pred_taken", i), 32'(if_predict_taken), 32'(vecs[i].ptk));
      check($sformatf("v%0d pred_target", i), if_predict_target, vecs[i].ptarget);
      if (vecs[i].upd) exp_upd++;
      if (vecs[i].mis) exp_mis++;
    end
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 32'h80);
    #1;
    check("table stat_updates", 32'(stat_updates), 32'(exp_upd));
    check("table stat_mispredicts", 32'(stat_mispredicts), 32'(exp_mis));

    // Five allocations, then reset asserted between edges with an update pending
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      drive(1, 32'h1000 + 32'(4 * k), 1, 32'h2000, 0, 0, 32'h1000);
    end
    @(negedge clock);
    drive(1, 32'h1014, 1, 32'h2000, 0, 0, 32'h1000);
    #1;
    check("pre-reset hit 0x1000", 32'(if_predict_hit), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async reset stat_updates", 32'(stat_updates), 0);
    check("async reset stat_mispredicts", 32'(stat_mispredicts), 0);
    check("async reset small stat_mispredicts", 32'(s_mispredicts), 0);
    check("async reset hit 0x1000", 32'(if_predict_hit), 0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 32'h1014);
    #1;
    check("discarded update hit 0x1014", 32'(if_predict_hit), 0);
    check("discarded update target", if_predict_target, 32'h1018);
    check("post reset stat_updates", 32'(stat_updates), 0);

    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      drive(1, 32'h2000 + 32'(4 * k), 1, 32'h3000, 0, 0, 32'h0);
    end
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    check("small stat_mispredicts sat", 32'(s_mispredicts), 15);
    check("small stat_updates sat", 32'(s_updates), 15);
    check("wide stat_mispredicts", 32'(stat_mispredicts), 20);
    check("wide stat_updates", 32'(stat_updates), 20);
    @(negedge clock);
    drive(1, 32'h2100, 1, 32'h3000, 0, 0, 32'h0);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    check("small stat_mispredicts hold", 32'(s_mispredicts), 15);
    check("wide stat_mispredicts 21", 32'(stat_mispredicts), 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
